// File: rtl/spi_rect_sequencer.sv
// Rectangle-fill sequencer: turns one fill request into CASET/PASET/RAMWR + pixel bytes.
// Optional build macro RECT_CLIP_EN enables panel-range rejection and x1/y1 clamping.
module spi_rect_sequencer #(
  parameter int unsigned WIDTH  = 240,
  parameter int unsigned HEIGHT = 320,
  parameter int unsigned CW     = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_init_done,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [CW-1:0] i_x0,
  input  logic [CW-1:0] i_x1,
  input  logic [CW-1:0] i_y0,
  input  logic [CW-1:0] i_y1,
  input  logic [15:0]   i_color,
  output logic [7:0]    o_byte,
  output logic          o_byte_dc,
  output logic          o_byte_valid,
  input  logic          i_byte_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

`ifdef RECT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam int unsigned DW = CW + 1;
  localparam int unsigned NW = 17;
  localparam int unsigned PW = 2 * DW;
  localparam logic [CW-1:0] X_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(HEIGHT - 1);
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE, CHECK, CASET_C, CASET_D, PASET_C, PASET_D, RAMWR_C, PIXEL
  } state_t;

  state_t        state, nxt;
  logic [1:0]    idx, idx_n;
  logic          phase, phase_n;
  logic [NW-1:0] pix_cnt, cnt_n;
  logic [CW-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [15:0]   color_q;

  logic          busy_n, done_n, err_n, valid_n, dc_n;
  logic [7:0]    byte_n;
  logic          accept, advance, oob, bad;
  logic [CW-1:0] x1_clamp, y1_clamp, x1_eff, y1_eff;
  logic [DW-1:0] w, h;

  // Zero-extend a coordinate to 16 bits and pick the requested byte.
  function automatic logic [7:0] coord_byte(input logic [CW-1:0] c, input logic hi);
    logic [15:0] e;
    e = 16'(c);
    return hi ? e[15:8] : e[7:0];
  endfunction

  assign o_req_ready = (state == IDLE) & i_init_done & ~i_rst;
  assign accept      = o_req_ready & i_req_valid;
  assign advance     = o_byte_valid & i_byte_ready;

  // Range check and clamping; with clipping disabled the raw corners pass through.
  always_comb begin
    x1_clamp = (32'(x1_q) > WIDTH - 1)  ? X_MAX : x1_q;
    y1_clamp = (32'(y1_q) > HEIGHT - 1) ? Y_MAX : y1_q;
    x1_eff   = CLIP_EN ? x1_clamp : x1_q;
    y1_eff   = CLIP_EN ? y1_clamp : y1_q;
    oob      = CLIP_EN & ((32'(x0_q) >= WIDTH) | (32'(y0_q) >= HEIGHT));
    bad      = oob | (x1_eff < x0_q) | (y1_eff < y0_q);
    w        = DW'(x1_eff) - DW'(x0_q) + DW'(1);
    h        = DW'(y1_eff) - DW'(y0_q) + DW'(1);
  end

  // Next-state logic; output bytes are derived from the next state so they can be registered.
  always_comb begin
    nxt     = state;
    idx_n   = idx;
    phase_n = phase;
    cnt_n   = pix_cnt;
    busy_n  = o_busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    valid_n = 1'b0;
    dc_n    = 1'b0;
    byte_n  = 8'h00;

    case (state)
      IDLE: begin
        if (accept) begin
          nxt    = CHECK;
          busy_n = 1'b1;
        end
      end
      CHECK: begin
        if (bad) begin
          nxt    = IDLE;
          err_n  = 1'b1;
          busy_n = 1'b0;
        end else begin
          nxt     = CASET_C;
          cnt_n   = NW'(PW'(w) * PW'(h));
          idx_n   = 2'd0;
          phase_n = 1'b0;
        end
      end
      CASET_C: if (advance) begin nxt = CASET_D; idx_n = 2'd0; end
      CASET_D: begin
        if (advance) begin
          if (idx == 2'd3) nxt = PASET_C;
          else             idx_n = idx + 2'd1;
        end
      end
      PASET_C: if (advance) begin nxt = PASET_D; idx_n = 2'd0; end
      PASET_D: begin
        if (advance) begin
          if (idx == 2'd3) nxt = RAMWR_C;
          else             idx_n = idx + 2'd1;
        end
      end
      RAMWR_C: if (advance) begin nxt = PIXEL; phase_n = 1'b0; end
      PIXEL: begin
        if (advance) begin
          phase_n = ~phase;
          if (phase) begin
            cnt_n = pix_cnt - NW'(1);
            if (pix_cnt == NW'(1)) begin
              nxt    = IDLE;
              done_n = 1'b1;
              busy_n = 1'b0;
            end
          end
        end
      end
      default: nxt = IDLE;
    endcase

    case (nxt)
      CASET_C: begin valid_n = 1'b1; byte_n = CMD_CASET; end
      CASET_D: begin
        valid_n = 1'b1;
        dc_n    = 1'b1;
        byte_n  = coord_byte(idx_n[1] ? x1_q : x0_q, ~idx_n[0]);
      end
      PASET_C: begin valid_n = 1'b1; byte_n = CMD_PASET; end
      PASET_D: begin
        valid_n = 1'b1;
        dc_n    = 1'b1;
        byte_n  = coord_byte(idx_n[1] ? y1_q : y0_q, ~idx_n[0]);
      end
      RAMWR_C: begin valid_n = 1'b1; byte_n = CMD_RAMWR; end
      PIXEL: begin
        valid_n = 1'b1;
        dc_n    = 1'b1;
        byte_n  = phase_n ? color_q[7:0] : color_q[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      phase        <= 1'b0;
      pix_cnt      <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      color_q      <= '0;
      o_byte       <= 8'h00;
      o_byte_dc    <= 1'b0;
      o_byte_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= nxt;
      idx          <= idx_n;
      phase        <= phase_n;
      pix_cnt      <= cnt_n;
      o_byte       <= byte_n;
      o_byte_dc    <= dc_n;
      o_byte_valid <= valid_n;
      o_busy       <= busy_n;
      o_done       <= done_n;
      o_err        <= err_n;
      if (accept) begin
        x0_q    <= i_x0;
        x1_q    <= i_x1;
        y0_q    <= i_y0;
        y1_q    <= i_y1;
        color_q <= i_color;
      end
      // Clamped end corners replace the raw ones before any address byte goes out.
      if (state == CHECK) begin
        x1_q <= x1_eff;
        y1_q <= y1_eff;
      end
    end
  end

endmodule
